// File: rtl/fetch_decode_queue.sv
// -----------------------------------------------------------------------------
// fetch_decode_queue
//
// Purpose:
//   Instruction queue between the fetch unit and the decode stage.
//   - Buffers {pc, instr} pairs in a small circular FIFO.
//   - Uses valid/ready handshakes on both sides.
//   - A PC redirect (flush) discards every buffered entry, so decode never
//     sees wrong-path instructions.
//   - Presents pre-sliced RISC-V style fields of the head entry.
//
// Optional feature (macro FDQ_BYPASS_EN):
//   When the queue is empty, the entry offered by fetch is forwarded to the
//   outputs in the same cycle. If decode accepts it in that cycle, it is
//   never written to storage.
//   With the macro undefined there is no combinational path from in_* to out_*.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 2)
//   AW     PC width
//   IW     instruction width
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   in_valid   fetch presents an entry
//   in_pc      PC of the offered entry
//   in_instr   instruction word of the offered entry
//   in_ready   queue accepts the offered entry this cycle
//   flush      PC redirect: drop everything (highest priority after reset)
//   out_valid  head entry valid for decode
//   out_pc     PC of the head entry (0 when out_valid=0)
//   out_instr  instruction word of the head entry (0 when out_valid=0)
//   out_opcode out_instr[6:0]
//   out_rd     out_instr[11:7]
//   out_rs1    out_instr[19:15]
//   out_rs2    out_instr[24:20]
//   out_ready  decode consumes the head entry this cycle
//   count      number of occupied entries
// -----------------------------------------------------------------------------
module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int IW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [AW-1:0]              in_pc,
  input  logic [IW-1:0]              in_instr,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [AW-1:0]              out_pc,
  output logic [IW-1:0]              out_instr,
  output logic [6:0]                 out_opcode,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] mem_pc    [DEPTH];
  logic [IW-1:0] mem_instr [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic full, empty;
  logic push, push_mem, pop_mem;
  logic bypass_active;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;

`ifdef FDQ_BYPASS_EN
  // Empty queue with a live offer: forward it straight to decode.
  assign bypass_active = empty && !flush && in_valid;
`else
  assign bypass_active = 1'b0;
`endif

  assign out_valid = (!empty && !flush) || bypass_active;

  // Storage pop only when a real head exists. A bypassed entry that decode
  // takes in the same cycle never touches storage.
  assign pop_mem  = !empty && !flush && out_ready;
  assign push_mem = push && !(bypass_active && out_ready);

  // Output mux: zero when nothing valid so decode never sees a stale head.
  always_comb begin
    out_pc    = '0;
    out_instr = '0;
    if (bypass_active) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end else if (out_valid) begin
      out_pc    = mem_pc[rd_ptr_q];
      out_instr = mem_instr[rd_ptr_q];
    end
  end

  assign out_opcode = out_instr[6:0];
  assign out_rd     = out_instr[11:7];
  assign out_rs1    = out_instr[19:15];
  assign out_rs2    = out_instr[24:20];
  assign count      = count_q;

  // Next-state for pointers and occupancy; flush wins over any handshake.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_mem) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_mem)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_mem, pop_mem})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is meaningful.
  // A flush cycle has in_ready=0, so push_mem is already low then.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push_mem && (wr_ptr_q == PW'(gi))) begin
          mem_pc[gi]    <= in_pc;
          mem_instr[gi] <= in_instr;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fetch_decode_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_decode_queue
//
// Self-checking bench for fetch_decode_queue.
// - A queue-based reference model tracks which entries must be held.
// - A compare process checks every output against that model on each falling
//   clock edge.
// - Directed sequences add hand-computed literal expectations that pin the
//   model itself.
// -----------------------------------------------------------------------------
module tb_fetch_decode_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [AW-1:0] in_pc;
  logic [IW-1:0] in_instr;
  logic          in_ready;
  logic          flush;
  logic          out_valid;
  logic [AW-1:0] out_pc;
  logic [IW-1:0] out_instr;
  logic [6:0]    out_opcode;
  logic [4:0]    out_rd;
  logic [4:0]    out_rs1;
  logic [4:0]    out_rs2;
  logic          out_ready;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  fetch_decode_queue #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_pc      (in_pc),
    .in_instr   (in_instr),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .out_opcode (out_opcode),
    .out_rd     (out_rd),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_ready  (out_ready),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } entry_t;

  entry_t model_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge reset) model_q.delete();

  // Model update on the active edge, using only the model's own occupancy.
  always @(posedge clk) begin
    if (!reset || flush) begin
      model_q.delete();
    end else begin
      bit has_head;
      bit do_pop;
      bit do_push;
      entry_t e;
      has_head = (model_q.size() != 0);
      do_pop   = has_head && out_ready;
      do_push  = in_valid && (model_q.size() != DEPTH);
`ifdef FDQ_BYPASS_EN
      // An empty-queue offer taken by decode in the same cycle is never stored.
      if (!has_head && in_valid && out_ready) do_push = 1'b0;
`endif
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        e.pc    = in_pc;
        e.instr = in_instr;
        model_q.push_back(e);
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    logic          exp_valid;
    logic          exp_ready;
    logic [AW-1:0] exp_pc;
    logic [IW-1:0] exp_instr;
    exp_ready = (model_q.size() != DEPTH) && !flush;
    exp_valid = (model_q.size() != 0) && !flush;
    exp_pc    = '0;
    exp_instr = '0;
    if (exp_valid) begin
      exp_pc    = model_q[0].pc;
      exp_instr = model_q[0].instr;
    end
`ifdef FDQ_BYPASS_EN
    if (model_q.size() == 0 && !flush && in_valid) begin
      exp_valid = 1'b1;
      exp_pc    = in_pc;
      exp_instr = in_instr;
    end
`endif
    chk("count",      64'(count),      64'(model_q.size()));
    chk("in_ready",   64'(in_ready),   64'(exp_ready));
    chk("out_valid",  64'(out_valid),  64'(exp_valid));
    chk("out_pc",     64'(out_pc),     64'(exp_pc));
    chk("out_instr",  64'(out_instr),  64'(exp_instr));
    chk("out_opcode", 64'(out_opcode), 64'(exp_instr[6:0]));
    chk("out_rd",     64'(out_rd),     64'(exp_instr[11:7]));
    chk("out_rs1",    64'(out_rs1),    64'(exp_instr[19:15]));
    chk("out_rs2",    64'(out_rs2),    64'(exp_instr[24:20]));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [AW-1:0] pc, input logic [IW-1:0] instr);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (DEPTH + 1) step();
    out_ready = 1'b0;
  endtask

  logic [IW-1:0] instr_tbl [3];

  initial begin
    instr_tbl[0] = 32'h0050_0093;
    instr_tbl[1] = 32'h0010_0113;
    instr_tbl[2] = 32'h0020_81B3;

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;

    // Reset state.
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc",    64'(out_pc),    64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    step();

    // Push 3 with decode stalled.
    for (int i = 0; i < 3; i++) push1(AW'(4 * i), instr_tbl[i]);
    @(negedge clk);
    chk("p3_count",  64'(count),      64'd3);
    chk("p3_ready",  64'(in_ready),   64'd1);
    chk("p3_pc",     64'(out_pc),     64'h0);
    chk("p3_opcode", 64'(out_opcode), 64'h13);
    chk("p3_rd",     64'(out_rd),     64'd1);
    step();

    // Fill, then offer a 5th entry that must be refused.
    push1(32'hC, 32'h0000_0013);
    in_valid = 1'b1;
    in_pc    = 32'h10;
    in_instr = 32'h0000_0033;
    @(negedge clk);
    chk("full_count", 64'(count),    64'd4);
    chk("full_ready", 64'(in_ready), 64'd0);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_pc", 64'(out_pc), 64'(4 * i));
      step();
    end
    out_ready = 1'b0;
    @(negedge clk);
    chk("drain_empty", 64'(count), 64'd0);
    step();

    // Steady stream at count=1 across several pointer wraps.
    push1(32'h100, 32'h0000_0093);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_pc    = 32'h104 + 32'(4 * k);
      in_instr = 32'h0000_0093 + 32'(k << 7);
      @(negedge clk);
      chk("stream_count", 64'(count),  64'd1);
      chk("stream_pc",    64'(out_pc), 64'(32'h100 + 32'(4 * k)));
      step();
    end
    in_valid = 1'b0;
    drain();

    // Flush with an offer in the same cycle.
    for (int i = 0; i < 3; i++) push1(AW'(4 * i), instr_tbl[i]);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_pc    = 32'h20;
    in_instr = 32'h0000_0113;
    @(negedge clk);
    chk("flush_ready", 64'(in_ready),  64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_flush_count", 64'(count),     64'd0);
    chk("post_flush_valid", 64'(out_valid), 64'd0);
    step();
    push1(32'h40, 32'h0000_0193);
    @(negedge clk);
    chk("flush_next_valid", 64'(out_valid), 64'd1);
    chk("flush_next_pc",    64'(out_pc),    64'h40);
    step();
    drain();

    // Asynchronous reset between edges.
    push1(32'h200, 32'h0000_0213);
    push1(32'h204, 32'h0000_0293);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_count", 64'(count),     64'd0);
    chk("arst_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    push1(32'h300, 32'h0000_0313);
    @(negedge clk);
    chk("arst_head_pc", 64'(out_pc), 64'h300);
    step();
    drain();

    // Empty queue, offer with decode ready: bypass or one-cycle latency.
    in_valid  = 1'b1;
    in_pc     = 32'h100;
    in_instr  = 32'h0000_0393;
    out_ready = 1'b1;
    @(negedge clk);
`ifdef FDQ_BYPASS_EN
    chk("byp_valid", 64'(out_valid), 64'd1);
    chk("byp_pc",    64'(out_pc),    64'h100);
`else
    chk("byp_valid", 64'(out_valid), 64'd0);
`endif
    step();
    in_valid = 1'b0;
    @(negedge clk);
`ifdef FDQ_BYPASS_EN
    chk("byp_count", 64'(count),     64'd0);
`else
    chk("byp_count", 64'(count),     64'd1);
    chk("byp_late",  64'(out_valid), 64'd1);
    chk("byp_lpc",   64'(out_pc),    64'h100);
`endif
    step();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
